// File: rtl/cuenta1_arb.sv
// Round-robin arbiter sharing one ones-counter among four requesters.
// Optional watchdog on the counter's fin handshake: define CUENTA1_ARB_TIMEOUT_EN.
module cuenta1_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [11:0] q_in,
    output logic [3:0]  gnt,
    output logic [2:0]  q_out,
    output logic        start_out,
    input  logic [3:0]  cuenta_in,
    input  logic        fin_in,
    output logic [3:0]  result,
    output logic [3:0]  done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  last_grant;
    logic [1:0]  win_idx;
    logic [1:0]  scan_idx;
    logic        win_found;
    logic [2:0]  win_q;
    logic        first_wait;
    logic        fin_accept;
    logic        timeout;

`ifdef CUENTA1_ARB_TIMEOUT_EN
    logic [4:0]  wait_cnt;
    logic        timed_out;
`endif

    // Round-robin search starting just after the last granted requester.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant;
        scan_idx  = last_grant;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_grant + 2'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        win_q = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (win_idx == 2'(i)) win_q = q_in[3*i +: 3];
        end
    end

    // The first WAIT cycle may still see fin from the previous operation.
    assign fin_accept = (state == S_WAIT) && !first_wait && fin_in;

`ifdef CUENTA1_ARB_TIMEOUT_EN
    assign timeout = (state == S_WAIT) && !fin_accept && (wait_cnt == 5'd15);
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (win_found) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (fin_accept || timeout) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // NOTE: only control/data registers are reset; there is no memory array here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt        <= 4'd0;
            q_out      <= 3'd0;
            last_grant <= 2'd3;
            result     <= 4'd0;
            first_wait <= 1'b0;
`ifdef CUENTA1_ARB_TIMEOUT_EN
            wait_cnt   <= 5'd0;
            timed_out  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt        <= 4'b0001 << win_idx;
                        q_out      <= win_q;
                        last_grant <= win_idx;
                    end
                end
                S_LAUNCH: begin
                    first_wait <= 1'b1;
`ifdef CUENTA1_ARB_TIMEOUT_EN
                    wait_cnt   <= 5'd0;
`endif
                end
                S_WAIT: begin
                    first_wait <= 1'b0;
`ifdef CUENTA1_ARB_TIMEOUT_EN
                    wait_cnt   <= wait_cnt + 5'd1;
                    if (timeout) begin
                        result    <= 4'hF;
                        timed_out <= 1'b1;
                    end
`endif
                    if (fin_accept) result <= cuenta_in;
                end
                S_DONE: begin
                    gnt <= 4'd0;
`ifdef CUENTA1_ARB_TIMEOUT_EN
                    timed_out <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign start_out = (state == S_LAUNCH);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) ? gnt : 4'd0;

`ifdef CUENTA1_ARB_TIMEOUT_EN
    assign err = (state == S_DONE) && timed_out;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cuenta1_arb.sv
// Self-checking bench for cuenta1_arb: emulated ones-counter, operation-level model, directed scenarios.
module tb_cuenta1_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] q_in;
    logic [3:0]  gnt;
    logic [2:0]  q_out;
    logic        start_out;
    logic [3:0]  cuenta_in;
    logic        fin_in;
    logic [3:0]  result;
    logic [3:0]  done;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    cuenta1_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .q_in      (q_in),
        .gnt       (gnt),
        .q_out     (q_out),
        .start_out (start_out),
        .cuenta_in (cuenta_in),
        .fin_in    (fin_in),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ones(input logic [2:0] v);
        return 4'(v[0]) + 4'(v[1]) + 4'(v[2]);
    endfunction

    // Emulated ones-counter: mode 0 answers fin_delay cycles after start, 1 = fin stuck high, 2 = stuck low.
    int fin_mode  = 0;
    int fin_delay = 1;
    int fin_cnt   = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_cnt = 0;
        end else begin
            case (fin_mode)
                1: fin_in = 1'b1;
                2: fin_in = 1'b0;
                default: begin
                    if (start_out) begin
                        fin_cnt = fin_delay;
                        fin_in  = 1'b0;
                    end else if (fin_cnt > 0) begin
                        fin_cnt--;
                        if (fin_cnt == 0) begin
                            fin_in    = 1'b1;
                            cuenta_in = ones(q_out);
                        end
                    end
                end
            endcase
        end
    end

    // Operation-level model: m_age counts cycles since the grant (0 = launch, 1 = ignored wait).
    int         m_age;
    bit         m_done;
    int         m_last;
    logic [3:0] m_gnt;
    logic [2:0] m_q;
    logic [3:0] m_result;
    bit         m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = -1; m_done = 0; m_last = 3; m_gnt = 0; m_q = 0; m_result = 0; m_err = 0;
        end else if (m_done) begin
            m_done = 0; m_gnt = 0; m_err = 0;
        end else if (m_age < 0) begin
            if (req != 4'd0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (req[(m_last + k) % 4]) begin
                        m_last = (m_last + k) % 4;
                        break;
                    end
                end
                m_gnt = 4'b0001 << m_last;
                m_q   = q_in[3*m_last +: 3];
                m_age = 0;
            end
        end else begin
            if (m_age >= 2 && fin_in) begin
                m_result = cuenta_in; m_done = 1; m_age = -1;
            end
`ifdef CUENTA1_ARB_TIMEOUT_EN
            else if (m_age == 16) begin
                m_result = 4'hF; m_err = 1; m_done = 1; m_age = -1;
            end
`endif
            else m_age++;
        end
    end

    always @(negedge clk) begin
        check("gnt",    16'(gnt),       16'(m_gnt));
        check("q_out",  16'(q_out),     16'(m_q));
        check("start",  16'(start_out), 16'(m_age == 0));
        check("done",   16'(done),      m_done ? 16'(m_gnt) : 16'd0);
        check("result", 16'(result),    16'(m_result));
        check("busy",   16'(busy),      16'(m_age >= 0 || m_done));
        check("err",    16'(err),       16'(m_done && m_err));
    end

    // Waits for a done pulse, counting launch and plain wait cycles on the way.
    task automatic run_op(input int limit, output logic [3:0] d, output int waits, output int starts,
                          output logic [3:0] r, output logic [2:0] qo, output logic e);
        d = 0; waits = 0; starts = 0; r = 0; qo = 0; e = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (start_out) starts++;
            else if (busy && done == 4'd0) waits++;
            if (done != 4'd0) begin
                d = done; r = result; qo = q_out; e = err;
                return;
            end
        end
        check("op_timeout", 16'd1, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [3:0] d, r;
    logic [2:0] qo;
    logic       e;
    int         waits, starts;
    int         order[5];

    initial begin
        rst_n = 1'b0; req = 0; q_in = 0; cuenta_in = 0; fin_in = 0;
        #13;
        check("rst_gnt",   16'(gnt),   16'd0);
        check("rst_busy",  16'(busy),  16'd0);
        check("rst_start", 16'(start_out), 16'd0);
        check("rst_q",     16'(q_out), 16'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single request, counter answers three cycles after start.
        @(negedge clk);
        fin_mode = 0; fin_delay = 3;
        req = 4'b0001; q_in = 12'b000_000_000_111;
        run_op(50, d, waits, starts, r, qo, e);
        req = 4'b0000;
        check("single_done",   16'(d),      16'b0001);
        check("single_result", 16'(r),      16'b0011);
        check("single_q",      16'(qo),     16'b111);
        check("single_starts", 16'(starts), 16'd1);
        check("single_waits",  16'(waits),  16'd3);
        check("model_result",  16'(m_result), 16'b0011);
        @(negedge clk);
        check("single_done_one", 16'(done), 16'd0);
        check("single_idle",     16'(busy), 16'd0);

        // Stale fin held high: done must not come before the second wait cycle.
        fin_mode = 1; cuenta_in = 4'd5;
        req = 4'b0010; q_in = 12'b000_000_011_000;
        run_op(50, d, waits, starts, r, qo, e);
        req = 4'b0000;
        check("stale_done",  16'(d),     16'b0010);
        check("stale_waits", 16'(waits), 16'd2);
        check("stale_result", 16'(r),    16'd5);

        // Operand changes during wait must not reach q_out or result.
        @(negedge clk);
        fin_mode = 0; fin_delay = 4; fin_in = 0;
        req = 4'b0100; q_in = 12'b000_101_000_000;
        for (int c = 0; c < 20 && !start_out; c++) @(negedge clk);
        @(negedge clk);
        q_in = 12'hFFF;
        run_op(50, d, waits, starts, r, qo, e);
        req = 4'b0000;
        check("hold_done",   16'(d),  16'b0100);
        check("hold_q",      16'(qo), 16'b101);
        check("hold_result", 16'(r),  16'b0010);

        // Round robin from reset with all four requesting continuously.
        do_reset();
        fin_delay = 1;
        req = 4'b1111; q_in = 12'b001_011_111_110;
        for (int n = 0; n < 5; n++) begin
            run_op(50, d, waits, starts, r, qo, e);
            order[n] = (d == 4'b0001) ? 0 : (d == 4'b0010) ? 1 : (d == 4'b0100) ? 2 : (d == 4'b1000) ? 3 : 9;
        end
        req = 4'b0000;
        check("rr_0", 16'(order[0]), 16'd0);
        check("rr_1", 16'(order[1]), 16'd1);
        check("rr_2", 16'(order[2]), 16'd2);
        check("rr_3", 16'(order[3]), 16'd3);
        check("rr_4", 16'(order[4]), 16'd0);

        // Reset while waiting aborts the operation; a later request is served afresh.
        @(negedge clk);
        fin_delay = 6;
        req = 4'b1000; q_in = 12'b101_000_000_000;
        for (int c = 0; c < 20 && !start_out; c++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 16'(busy), 16'd1);
        #2 rst_n = 1'b0; req = 4'b0000;
        #1;
        check("mid_rst_gnt",    16'(gnt),    16'd0);
        check("mid_rst_q",      16'(q_out),  16'd0);
        check("mid_rst_done",   16'(done),   16'd0);
        check("mid_rst_busy",   16'(busy),   16'd0);
        check("mid_rst_result", 16'(result), 16'd0);
        check("mid_rst_err",    16'(err),    16'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 16'(done), 16'd0);
        fin_delay = 1;
        req = 4'b0100; q_in = 12'b000_110_000_000;
        run_op(50, d, waits, starts, r, qo, e);
        req = 4'b0000;
        check("post_rst_served", 16'(d), 16'b0100);
        check("post_rst_result", 16'(r), 16'd2);

        // Counter never answers.
        @(negedge clk);
        fin_mode = 2;
        req = 4'b0010; q_in = 12'b000_000_001_000;
`ifdef CUENTA1_ARB_TIMEOUT_EN
        run_op(80, d, waits, starts, r, qo, e);
        req = 4'b0000;
        check("to_done",   16'(d),     16'b0010);
        check("to_result", 16'(r),     16'hF);
        check("to_err",    16'(e),     16'd1);
        check("to_waits",  16'(waits), 16'd16);
        @(negedge clk);
        check("to_err_one", 16'(err), 16'd0);
`else
        repeat (40) @(negedge clk);
        check("hang_busy", 16'(busy), 16'd1);
        check("hang_err",  16'(err),  16'd0);
        req = 4'b0000;
`endif
        do_reset();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cuenta1_arb.md
CUENTA1_ARB -- requirements
Module: cuenta1_arb

Interface
REQ-001 The block SHALL have a single clock `clk`, input, 1 bit; all state updates on its rising edge.
REQ-002 The block SHALL have `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have `req`, input, 4 bits: per-requester level request, bit i = requester i.
REQ-004 The block SHALL have `q_in`, input, 12 bits: requester data, requester i on bits [3i+2:3i].
REQ-005 The block SHALL have `gnt`, output, 4 bits: one-hot grant, or all-zero when idle.
REQ-006 The block SHALL have `q_out`, output, 3 bits: operand driven to the shared ones-counter.
REQ-007 The block SHALL have `start_out`, output, 1 bit: one-cycle start pulse to the ones-counter.
REQ-008 The block SHALL have `cuenta_in`, input, 4 bits: count result from the ones-counter.
REQ-009 The block SHALL have `fin_in`, input, 1 bit: completion flag from the ones-counter.
REQ-010 The block SHALL have `result`, output, 4 bits: latched count for the granted requester.
REQ-011 The block SHALL have `done`, output, 4 bits: one-cycle completion pulse for requester i.
REQ-012 The block SHALL have `busy`, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have `err`, output, 1 bit: one-cycle timeout pulse (see Configuration).

Function
REQ-014 The FSM SHALL have four states, IDLE, LAUNCH, WAIT and DONE, with transitions IDLE->LAUNCH->WAIT->DONE->IDLE.
REQ-015 In IDLE with any req bit high, the block SHALL select the winner round-robin, searching from last_grant+1 modulo 4, and go to LAUNCH next cycle.
REQ-016 In IDLE with req=0, the block SHALL stay in IDLE with gnt=0 and start_out=0.
REQ-017 On entry to LAUNCH, the block SHALL register gnt (one-hot winner), q_out (winner's q_in slice) and last_grant; gnt and q_out SHALL stay stable until DONE ends.
REQ-018 start_out SHALL be 1 for exactly the LAUNCH cycle, and 0 in every other cycle.
REQ-019 In its first cycle, WAIT SHALL ignore fin_in (this masks stale fin from a previous operation); afterwards, fin_in=1 SHALL move the FSM to DONE.
REQ-020 On the WAIT->DONE edge, the block SHALL latch result from cuenta_in; result SHALL hold until the next DONE.
REQ-021 In DONE, done[i]=1 SHALL be driven for the granted i only, for one cycle; then the FSM SHALL return to IDLE with gnt=0.
REQ-022 Minimum latency from req sampled in IDLE to done SHALL be 4 cycles (IDLE, LAUNCH, WAIT x1 ignored, WAIT with fin, then DONE).
REQ-023 Requester i SHALL hold req[i] and its q_in slice stable until done[i]; a req[i] still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-024 Changes to req or q_in while busy=1 SHALL NOT affect the current operation.
REQ-025 With simultaneous requests, each requester SHALL be served within 4 grants (no starvation).

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, gnt=0, q_out=0, start_out=0, result=0, done=0, busy=0, err=0, and last_grant=3, so requester 0 has first priority.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release, the block SHALL arbitrate afresh from IDLE.

Configuration
REQ-028 With macro CUENTA1_ARB_TIMEOUT_EN defined, a 5-bit watchdog SHALL count WAIT cycles; on 16 WAIT cycles without accepted fin_in, the block SHALL go to DONE with result=4'hF, done[i] pulsed and err=1 for that cycle.
REQ-029 Without CUENTA1_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely for fin_in, and err SHALL be tied to 0.

Verification
REQ-030 Single request: req=0001, q_in[2:0]=111, model returns fin after 3 cycles with cuenta=0011 -> start_out pulses once, q_out=111, done=0001 one cycle, result=0011.
REQ-031 Round-robin: req=1111 held, each requester re-requesting after its done -> grant order 0,1,2,3,0; each done matches its gnt.
REQ-032 Stale fin: fin_in held 1 through LAUNCH and the first WAIT cycle -> DONE not entered before the second WAIT cycle.
REQ-033 Data hold: q_in changed during WAIT -> q_out and result unaffected (q_in=101 gives result=0010).
REQ-034 Reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 immediately, no done; next req=0100 is served normally.
REQ-035 Timeout (macro defined): fin_in stuck 0 after req=0010 -> after 16 WAIT cycles done=0010, result=1111, err=1 for one cycle; macro undefined -> busy stays 1, err=0.
